// File: rtl/mem_arb_pkg.sv
// Purpose : shared FSM state encoding and grant identifiers for the memory port arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

endpackage

// File: rtl/arb_req_latch.sv
// Purpose : holds one port's pending request (flag + address/we/wdata/wmask) until serviced.
// Latency : a pulse sampled at an edge is visible on pending_o/fields the following cycle.
// Backpressure: a pulse while pending is dropped unless the same edge also clears (set wins).
//
// Ports: clk, rst (sync, active-high); set_vld request pulse; clr_vld completion;
//        *_i request fields captured on an accepted pulse; pending_o and *_o registered copies.
module arb_req_latch #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_vld,
    input  logic                clr_vld,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wmask_i,
    output logic                pending_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                we_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wmask_o
);

    logic                pending_q, pending_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                we_q,      we_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [DATA_W/8-1:0] wmask_q,   wmask_d;
    logic                accept;

    always_comb begin
        // A pulse landing on the completion edge re-arms the latch with the new request.
        accept    = set_vld && (!pending_q || clr_vld);
        pending_d = pending_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        if (accept) begin
            pending_d = 1'b1;
            addr_d    = addr_i;
            we_d      = we_i;
            wdata_d   = wdata_i;
            wmask_d   = wmask_i;
        end else if (clr_vld) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
        end
    end

    assign pending_o = pending_q;
    assign addr_o    = addr_q;
    assign we_o      = we_q;
    assign wdata_o   = wdata_q;
    assign wmask_o   = wmask_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : merges the MMU fetch port and data port onto one single-outstanding memory bus.
// Latency : pulse at edge0 -> stall high cycles 1..3, data valid cycle 4 (ready=1, rvalid one cycle after accept).
// Backpressure: mem_valid and all bus fields held stable until mem_ready; stall stays high meanwhile.
//
// Ports: clk, rst (sync, active-high); fetch port if_addr/if_req -> if_rdata/if_stall;
//        data port d_addr/d_en/d_we/d_wdata/d_wmask -> d_rdata/d_stall;
//        bus mem_addr/mem_valid/mem_we/mem_wdata/mem_wmask, mem_ready, mem_rvalid/mem_rdata.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter bit PRIO_DATA = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_req,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_en,
    input  logic                d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int   MASK_W = DATA_W / 8;
    // Port that wins a tie when the alternation bit is clear.
    localparam logic PREF   = PRIO_DATA ? GRANT_D : GRANT_IF;

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_tie_q, last_tie_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_clr, d_clr;

    logic              if_pend, d_pend;
    logic [ADDR_W-1:0] if_addr_r, d_addr_r;
    logic              if_we_r, d_we_r;
    logic [DATA_W-1:0] if_wdata_r, d_wdata_r;
    logic [MASK_W-1:0] if_wmask_r, d_wmask_r;

    // Fetch port is read-only; its write fields are tied off.
    arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if_latch (
        .clk       (clk),
        .rst       (rst),
        .set_vld   (if_req),
        .clr_vld   (if_clr),
        .addr_i    (if_addr),
        .we_i      (1'b0),
        .wdata_i   ({DATA_W{1'b0}}),
        .wmask_i   ({MASK_W{1'b0}}),
        .pending_o (if_pend),
        .addr_o    (if_addr_r),
        .we_o      (if_we_r),
        .wdata_o   (if_wdata_r),
        .wmask_o   (if_wmask_r)
    );

    arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_d_latch (
        .clk       (clk),
        .rst       (rst),
        .set_vld   (d_en),
        .clr_vld   (d_clr),
        .addr_i    (d_addr),
        .we_i      (d_we),
        .wdata_i   (d_wdata),
        .wmask_i   (d_wmask),
        .pending_o (d_pend),
        .addr_o    (d_addr_r),
        .we_o      (d_we_r),
        .wdata_o   (d_wdata_r),
        .wmask_o   (d_wmask_r)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_tie_d = last_tie_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_clr     = 1'b0;
        d_clr      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (if_pend && d_pend) begin
                    // Alternation bit set means the preferred port took the last tie.
                    grant_d    = last_tie_q ? ~PREF : PREF;
                    last_tie_d = ~last_tie_q;
                    state_d    = ARB_ISSUE;
                end else if (if_pend || d_pend) begin
                    grant_d = d_pend ? GRANT_D : GRANT_IF;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_ready) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ARB_IDLE;
                    if (grant_q == GRANT_IF) begin
                        if_clr     = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_clr = 1'b1;
                        if (!d_we_r) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= GRANT_IF;
            last_tie_q <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_tie_q <= last_tie_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Bus fields are zero outside ISSUE so the bus is quiet whenever no request is offered.
    always_comb begin
        mem_valid = (state_q == ARB_ISSUE);
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (mem_valid) begin
            if (grant_q == GRANT_D) begin
                mem_addr  = d_addr_r;
                mem_we    = d_we_r;
                mem_wdata = d_wdata_r;
                mem_wmask = d_wmask_r;
            end else begin
                mem_addr  = if_addr_r;
                mem_we    = if_we_r;
                mem_wdata = if_wdata_r;
                mem_wmask = if_wmask_r;
            end
        end
    end

    assign if_stall = if_pend;
    assign d_stall  = d_pend;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] if_addr;
    logic        if_req;
    logic [63:0] if_rdata;
    logic        if_stall;
    logic [63:0] d_addr;
    logic        d_en;
    logic        d_we;
    logic [63:0] d_wdata;
    logic [7:0]  d_wmask;
    logic [63:0] d_rdata;
    logic        d_stall;
    logic [63:0] mem_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .PRIO_DATA(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_addr    (if_addr),
        .if_req     (if_req),
        .if_rdata   (if_rdata),
        .if_stall   (if_stall),
        .d_addr     (d_addr),
        .d_en       (d_en),
        .d_we       (d_we),
        .d_wdata    (d_wdata),
        .d_wmask    (d_wmask),
        .d_rdata    (d_rdata),
        .d_stall    (d_stall),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays the memory side of one transaction: waits for mem_valid, holds
    // mem_ready low ready_delay cycles, accepts, then responds next cycle.
    task automatic bus_serve(input logic [63:0] rd, input int ready_delay,
                             output logic [63:0] addr, output logic we,
                             output logic [63:0] wdata, output logic [7:0] wmask,
                             output bit stable, output int n_ticks, output bit timeout);
        int guard;
        addr = '0; we = 1'b0; wdata = '0; wmask = '0;
        stable = 1'b1; timeout = 1'b0; n_ticks = 0; guard = 0;
        while (mem_valid !== 1'b1 && guard < 20) begin
            tick(); n_ticks++; guard++;
        end
        if (mem_valid !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        addr = mem_addr; we = mem_we; wdata = mem_wdata; wmask = mem_wmask;
        for (int i = 0; i < ready_delay; i++) begin
            tick(); n_ticks++;
            if (mem_valid !== 1'b1 || mem_addr !== addr || mem_we !== we ||
                mem_wdata !== wdata || mem_wmask !== wmask) stable = 1'b0;
        end
        mem_ready = 1'b1;
        tick(); n_ticks++;
        mem_ready = 1'b0;
        if (mem_valid !== 1'b0) stable = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick(); n_ticks++;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if (if_stall !== 1'b0 || d_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: if=%b d=%b, want 0 0", if_stall, d_stall);
        end
        n_checks++;
        if (mem_valid !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus_ctl: valid=%b we=%b, want 0 0", mem_valid, mem_we);
        end
        n_checks++;
        if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_wmask !== 8'h0) begin
            n_fail++; $display("FAIL reset_bus_dat: addr=%h wdata=%h wmask=%h, want 0", mem_addr, mem_wdata, mem_wmask);
        end
        n_checks++;
        if (if_rdata !== 64'h0 || d_rdata !== 64'h0) begin
            n_fail++; $display("FAIL reset_rdata: if=%h d=%h, want 0", if_rdata, d_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lone_fetch();
        int hi = 0;
        if_addr = 64'h8000_0000; if_req = 1'b1;
        tick();                                  // cycle 1
        if_req = 1'b0;
        if (if_stall === 1'b1) hi++;
        tick();                                  // cycle 2: ISSUE
        if (if_stall === 1'b1) hi++;
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL fetch_issue: valid=%b addr=%h we=%b, want 1 80000000 0", mem_valid, mem_addr, mem_we);
        end
        mem_ready = 1'b1;
        tick();                                  // cycle 3: WAIT
        mem_ready = 1'b0;
        if (if_stall === 1'b1) hi++;
        mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        tick();                                  // cycle 4
        mem_rvalid = 1'b0;
        n_checks++;
        if (hi != 3 || if_stall !== 1'b0) begin
            n_fail++; $display("FAIL fetch_stall_len: high=%0d stall_c4=%b, want 3 0", hi, if_stall);
        end
        n_checks++;
        if (if_rdata !== 64'h1234) begin
            n_fail++; $display("FAIL fetch_rdata: got %h want 1234", if_rdata);
        end
        n_checks++;
        if (d_stall !== 1'b0) begin
            n_fail++; $display("FAIL fetch_d_stall: got %b want 0", d_stall);
        end
    endtask

    task automatic test_tie();
        logic [63:0] a, wd; logic w; logic [7:0] wm; bit st, to; int nt;
        for (int round = 0; round < 2; round++) begin
            if_addr = 64'h1000 + 64'(round); d_addr = 64'h2000 + 64'(round);
            if_req = 1'b1; d_en = 1'b1; d_we = 1'b0;
            tick();
            if_req = 1'b0; d_en = 1'b0;
            bus_serve(64'h11 + 64'(round), 0, a, w, wd, wm, st, nt, to);
            n_checks++;
            // Round 0: data wins (preferred); round 1: fetch wins (alternation).
            if (to || a !== (round == 0 ? 64'h2000 : 64'h1001)) begin
                n_fail++; $display("FAIL tie%0d_first: addr=%h timeout=%b, want %h", round, a, to, (round == 0 ? 64'h2000 : 64'h1001));
            end
            n_checks++;
            if ((round == 0) ? (d_stall !== 1'b0 || if_stall !== 1'b1 || d_rdata !== 64'h11)
                             : (if_stall !== 1'b0 || d_stall !== 1'b1 || if_rdata !== 64'h12)) begin
                n_fail++; $display("FAIL tie%0d_mid: if_stall=%b d_stall=%b if_rdata=%h d_rdata=%h", round, if_stall, d_stall, if_rdata, d_rdata);
            end
            bus_serve(64'h21 + 64'(round), 0, a, w, wd, wm, st, nt, to);
            n_checks++;
            if (to || a !== (round == 0 ? 64'h1000 : 64'h2001) || if_stall !== 1'b0 || d_stall !== 1'b0) begin
                n_fail++; $display("FAIL tie%0d_second: addr=%h timeout=%b stalls=%b%b", round, a, to, if_stall, d_stall);
            end
        end
        n_checks++;
        if (if_rdata !== 64'h12 || d_rdata !== 64'h22) begin
            n_fail++; $display("FAIL tie_rdata: if=%h d=%h, want 12 22", if_rdata, d_rdata);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, wd; logic w; logic [7:0] wm; bit st, to; int nt;
        d_addr = 64'hCAFE_0000; d_we = 1'b0; d_wdata = 64'h5555; d_en = 1'b1;
        tick();
        d_en = 1'b0;
        bus_serve(64'h33, 5, a, w, wd, wm, st, nt, to);
        n_checks++;
        if (to || !st || a !== 64'hCAFE_0000) begin
            n_fail++; $display("FAIL bp_stable: timeout=%b stable=%b addr=%h, want 0 1 cafe0000", to, st, a);
        end
        n_checks++;
        if (nt != 8 || d_stall !== 1'b0 || d_rdata !== 64'h33) begin
            n_fail++; $display("FAIL bp_stall_len: ticks=%0d stall=%b rdata=%h, want 8 0 33", nt, d_stall, d_rdata);
        end
        tick(); tick();
        n_checks++;
        if (mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_dup: mem_valid=%b want 0", mem_valid);
        end
    endtask

    task automatic test_write();
        logic [63:0] a, wd; logic w; logic [7:0] wm; bit st, to; int nt;
        d_addr = 64'h40; d_we = 1'b1; d_wmask = 8'h0F; d_wdata = 64'hAA; d_en = 1'b1;
        tick();
        d_en = 1'b0; d_we = 1'b0;
        bus_serve(64'hDEAD, 0, a, w, wd, wm, st, nt, to);
        n_checks++;
        if (to || a !== 64'h40 || w !== 1'b1 || wd !== 64'hAA || wm !== 8'h0F) begin
            n_fail++; $display("FAIL wr_issue: addr=%h we=%b wdata=%h wmask=%h, want 40 1 aa 0f", a, w, wd, wm);
        end
        n_checks++;
        if (d_rdata !== 64'h33 || d_stall !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: rdata=%h stall=%b, want 33 0", d_rdata, d_stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, wd; logic w; logic [7:0] wm; bit st, to; int nt;
        int lo = 0;
        if_addr = 64'hA100; if_req = 1'b1;
        tick();                                  // cycle 1
        if_req = 1'b0;
        if (if_stall !== 1'b1) lo++;
        tick();                                  // cycle 2: ISSUE
        if (if_stall !== 1'b1) lo++;
        mem_ready = 1'b1;
        tick();                                  // cycle 3: WAIT
        mem_ready = 1'b0;
        if (if_stall !== 1'b1) lo++;
        mem_rvalid = 1'b1; mem_rdata = 64'h55;
        if_req = 1'b1; if_addr = 64'hA200;       // new pulse on the completion edge
        tick();                                  // cycle 4
        mem_rvalid = 1'b0; if_req = 1'b0;
        if (if_stall !== 1'b1) lo++;
        n_checks++;
        if (lo != 0 || if_rdata !== 64'h55) begin
            n_fail++; $display("FAIL b2b_first: low_cycles=%0d rdata=%h, want 0 55", lo, if_rdata);
        end
        bus_serve(64'h66, 0, a, w, wd, wm, st, nt, to);
        n_checks++;
        if (to || a !== 64'hA200 || if_stall !== 1'b0 || if_rdata !== 64'h66) begin
            n_fail++; $display("FAIL b2b_second: addr=%h stall=%b rdata=%h timeout=%b, want a200 0 66 0", a, if_stall, if_rdata, to);
        end
    endtask

    task automatic test_reset_in_wait();
        d_addr = 64'h7000; d_we = 1'b0; d_en = 1'b1;
        tick();
        d_en = 1'b0;
        tick();                                  // ISSUE
        mem_ready = 1'b1;
        tick();                                  // WAIT
        mem_ready = 1'b0;
        n_checks++;
        if (mem_valid !== 1'b0 || d_stall !== 1'b1) begin
            n_fail++; $display("FAIL rstw_pre: valid=%b stall=%b, want 0 1", mem_valid, d_stall);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
        tick();
        mem_rvalid = 1'b0;
        tick();
        n_checks++;
        if (d_stall !== 1'b0 || if_stall !== 1'b0 || mem_valid !== 1'b0 || mem_addr !== 64'h0) begin
            n_fail++; $display("FAIL rstw_idle: stalls=%b%b valid=%b addr=%h, want 00 0 0", if_stall, d_stall, mem_valid, mem_addr);
        end
        n_checks++;
        if (d_rdata !== 64'h0 || if_rdata !== 64'h0) begin
            n_fail++; $display("FAIL rstw_rdata: d=%h if=%h, want 0 0", d_rdata, if_rdata);
        end
    endtask

    initial begin
        rst = 1'b1; if_addr = '0; if_req = 1'b0; d_addr = '0; d_en = 1'b0; d_we = 1'b0;
        d_wdata = '0; d_wmask = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_lone_fetch();
        test_tie();
        test_backpressure();
        test_write();
        test_back_to_back();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
